alu_cmd_loader: RTL and testbench

Byte-serial command front end for the 32-bit ALU. It accepts a 9-byte command stream: one opcode byte, then operand A, then operand B. It drives the ALU operand and opcode inputs, captures the ALU's combinational result and flags one cycle later, and presents them with a one-cycle valid pulse. It sits directly upstream of the ALU, between the board-level input logic (switches or UART byte source) and the ALU, and also registers the ALU outputs for display.

---
 rtl/alu_cmd_loader_pkg.sv | 27 ++
 rtl/alu_cmd_loader_byte_assembler.sv | 25 ++
 rtl/alu_cmd_loader.sv | 117 +++++++++++
 tb/tb_alu_cmd_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_cmd_loader_pkg.sv
// Shared definitions for the ALU command loader: default width, ALU opcodes
// and FSM state encodings.
package alu_cmd_loader_pkg;

  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // States in which the loader takes bytes from the source.
  function automatic logic accepts_bytes(input logic [2:0] st);
    return (st == ST_IDLE) || (st == ST_LOAD_A) || (st == ST_LOAD_B);
  endfunction

endpackage

// File: rtl/alu_cmd_loader_byte_assembler.sv
// Little-endian operand register loaded one byte at a time by byte index.
module alu_cmd_loader_byte_assembler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [7:0]        din,
  output logic [DATA_W-1:0] q
);
  localparam int unsigned NB = DATA_W / 8;

  for (genvar i = 0; i < NB; i++) begin : g_byte
    always_ff @(posedge clk) begin
      if (rst) begin
        q[i*8 +: 8] <= 8'h00;
      end else if (we && (idx == IDX_W'(i))) begin
        q[i*8 +: 8] <= din;
      end
    end
  end

endmodule

// File: rtl/alu_cmd_loader.sv
// Byte-serial command front end for the ALU: opcode, operand A, operand B in,
// registered result and flags out. Define OF_STICKY_EN for a sticky overflow flag.
module alu_cmd_loader
  import alu_cmd_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_zf,
  input  logic              alu_of,
  output logic [DATA_W-1:0] res_f,
  output logic              res_zf,
  output logic              res_of,
  output logic              res_valid,
  output logic              busy
);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

  logic [2:0]       state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic             xfer, last_byte, we_a, we_b;
  logic             opcode_unused;

  assign xfer      = in_valid && in_ready;
  assign last_byte = (cnt == IDX_W'(NB - 1));
  assign we_a      = xfer && (state == ST_LOAD_A);
  assign we_b      = xfer && (state == ST_LOAD_B);

`ifdef OF_STICKY_EN
  assign opcode_unused = ^in_data[6:3];
`else
  assign opcode_unused = ^in_data[7:3];
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (xfer) state_nxt = ST_LOAD_A;
      ST_LOAD_A: if (xfer && last_byte) state_nxt = ST_LOAD_B;
      ST_LOAD_B: if (xfer && last_byte) state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  alu_cmd_loader_byte_assembler #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_asm_a (
    .clk (clk),
    .rst (rst),
    .we  (we_a),
    .idx (cnt),
    .din (in_data),
    .q   (alu_a)
  );

  alu_cmd_loader_byte_assembler #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_asm_b (
    .clk (clk),
    .rst (rst),
    .we  (we_b),
    .idx (cnt),
    .din (in_data),
    .q   (alu_b)
  );

  // Status outputs are decoded from the next state so they are plain flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      alu_op    <= 3'b000;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_f     <= '0;
      res_zf    <= 1'b0;
      res_of    <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= accepts_bytes(state_nxt);
      busy      <= (state_nxt == ST_EXEC) || (state_nxt == ST_DONE);
      res_valid <= (state_nxt == ST_DONE);
      if (xfer) begin
        if (state == ST_IDLE) begin
          alu_op <= in_data[2:0];
          cnt    <= '0;
        end else begin
          cnt <= last_byte ? '0 : cnt + IDX_W'(1);
        end
      end
      if (state == ST_EXEC) begin
        res_f  <= alu_f;
        res_zf <= alu_zf;
      end
`ifdef OF_STICKY_EN
      if (state == ST_EXEC) begin
        res_of <= res_of | alu_of;
      end else if (xfer && (state == ST_IDLE) && in_data[7]) begin
        res_of <= 1'b0;
      end
`else
      if (state == ST_EXEC) begin
        res_of <= alu_of;
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_cmd_loader.sv
// Scoreboard bench for alu_cmd_loader with a behavioural ALU and command model.
module tb_alu_cmd_loader;

  typedef struct packed {
    logic [31:0] f;
    logic        zf;
    logic        of;
  } alu_res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] f;
    logic        zf;
    logic        of;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_a, alu_b, alu_f, res_f;
  logic [2:0]  alu_op;
  logic        alu_zf, alu_of, res_zf, res_of, res_valid, busy;

  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  int unsigned xfer_cyc = 0;
  logic        acc_of = 1'b0;
  exp_t        sb[$];
  exp_t        mon_e;
  alu_res_t    env_res;

  alu_cmd_loader #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_f     (alu_f),
    .alu_zf    (alu_zf),
    .alu_of    (alu_of),
    .res_f     (res_f),
    .res_zf    (res_zf),
    .res_of    (res_of),
    .res_valid (res_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Plain-arithmetic ALU: signed overflow judged on 64-bit results.
  function automatic alu_res_t ref_alu(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    alu_res_t r;
    longint sa, sb_, s;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    r.of = 1'b0;
    case (op)
      3'd0: r.f = a & b;
      3'd1: r.f = a | b;
      3'd2: r.f = a ^ b;
      3'd3: r.f = ~(a | b);
      3'd4: begin
        s = sa + sb_;
        r.f = 32'(s);
        r.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd5: begin
        s = sa - sb_;
        r.f = 32'(s);
        r.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      3'd6: r.f = (sa < sb_) ? 32'd1 : 32'd0;
      default: r.f = a << b[4:0];
    endcase
    r.zf = (r.f == 32'd0);
    return r;
  endfunction

  always_comb begin
    env_res = ref_alu(alu_op, alu_a, alu_b);
    alu_f   = env_res.f;
    alu_zf  = env_res.zf;
    alu_of  = env_res.of;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Entered and left on a falling edge; in_valid is dropped on return.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    guard = 0;
    repeat (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    xfer_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_operands(input logic [7:0] opbyte, input logic [31:0] a,
                               input logic [31:0] b, input int gapmax);
    exp_t e;
    alu_res_t r;
    for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8], $urandom_range(gapmax, 0));
    for (int i = 0; i < 4; i++) send_byte(b[i*8 +: 8], $urandom_range(gapmax, 0));
    r = ref_alu(opbyte[2:0], a, b);
`ifdef OF_STICKY_EN
    if (opbyte[7]) acc_of = 1'b0;
    acc_of = acc_of | r.of;
`else
    acc_of = r.of;
`endif
    e.a = a; e.b = b; e.op = opbyte[2:0];
    e.f = r.f; e.zf = r.zf; e.of = acc_of;
    e.cyc = xfer_cyc + 2;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input logic [7:0] opbyte, input logic [31:0] a,
                          input logic [31:0] b, input int gapmax);
    send_byte(opbyte, $urandom_range(gapmax, 0));
    send_operands(opbyte, a, b, gapmax);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    acc_of = 1'b0;
  endtask

  task automatic check_reset_state();
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_res_f", res_f, 0);
    check("rst_res_zf", res_zf, 0);
    check("rst_res_of", res_of, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (sb.size() == 0) begin
        check("res_valid_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("res_f", res_f, mon_e.f);
        check("res_zf", res_zf, mon_e.zf);
        check("res_of", res_of, mon_e.of);
        check("res_cycle", 64'(cyc), 64'(mon_e.cyc));
        check("alu_a", alu_a, mon_e.a);
        check("alu_b", alu_b, mon_e.b);
        check("alu_op", alu_op, mon_e.op);
        check("busy_done", busy, 1);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] specials [4];
    specials[0] = 32'h7FFFFFFF; specials[1] = 32'h80000000;
    specials[2] = 32'h00000000; specials[3] = 32'hFFFFFFFF;

    @(negedge clk);
    do_reset();
    check_reset_state();

    // Overflowing ADD, then a byte held through EXEC/DONE.
    send_cmd(8'h04, 32'h7FFFFFFF, 32'h00000001, 0);
    in_data = 8'h01;
    in_valid = 1'b1;
    check("bp_ready_exec", in_ready, 0);
    check("bp_busy_exec", busy, 1);
    @(negedge clk);
    check("bp_ready_done", in_ready, 0);
    @(negedge clk);
    check("bp_ready_idle", in_ready, 1);
    check("bp_busy_idle", busy, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_opcode", alu_op, 3'b001);
    send_operands(8'h01, 32'h0000000F, 32'h000000F0, 0);

    send_cmd(8'h05, 32'h00000005, 32'h00000005, 0);

    // Sticky sequence: overflow, AND, then clearing opcode.
    send_cmd(8'h04, 32'h7FFFFFFF, 32'h00000001, 0);
    send_cmd(8'h00, 32'h0000000F, 32'h000000FF, 0);
    send_cmd(8'h80, 32'h00000000, 32'h00000000, 0);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(3, 0)] : $urandom;
      rb = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(3, 0)] : $urandom;
      send_cmd(8'($urandom), ra, rb, (n % 2 == 0) ? 0 : 3);
    end

    // Reset in the middle of loading A.
    send_byte(8'h04, 0);
    for (int i = 0; i < 3; i++) send_byte(8'hA5, 1);
    do_reset();
    check_reset_state();
    send_byte(8'h02, 0);
    check("post_rst_opcode", alu_op, 3'b010);
    send_operands(8'h02, 32'h12345678, 32'hFFFF0000, 2);

    repeat (6) @(negedge clk);
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
